// File: rtl/md_unit_if.sv
// Request/MTHI-MTLO/result bundle between the execute stage and md_unit.
// The master drives requests and register writes; the slave returns status and HI/LO.
interface md_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;
    logic            mthi_we;
    logic            mtlo_we;
    logic [XLEN-1:0] mt_wdata;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output req_valid, req_op, req_src1, req_src2, mthi_we, mtlo_we, mt_wdata, flush,
        input  req_ready, busy, done, hi, lo
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, mthi_we, mtlo_we, mt_wdata, flush,
        output req_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO: multi-cycle multiply with accumulate,
// restoring radix-2 divider with a final sign-fixup cycle, and flush abort.
module md_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input logic       clk,
    input logic       resetn,
    md_unit_if.slave  bus
);
    localparam int unsigned CntMax = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned W2     = 2 * XLEN;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDfix} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;   // multiplicand, or dividend magnitude shifting into quotient
    logic [XLEN-1:0] b_q, b_d;   // multiplier, or divisor magnitude
    logic [XLEN-1:0] r_q, r_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            done_q, done_d;

    function automatic logic [W2-1:0] mul_acc(input logic [2:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b, input logic [W2-1:0] acc);
        logic          sgn;
        logic [W2-1:0] ea, eb, prod;
        sgn  = ~op[0];
        ea   = {{XLEN{sgn & a[XLEN-1]}}, a};
        eb   = {{XLEN{sgn & b[XLEN-1]}}, b};
        prod = ea * eb;
        if (!op[2]) begin
            mul_acc = prod;
        end else if (op[1]) begin
            mul_acc = acc - prod;
        end else begin
            mul_acc = acc + prod;
        end
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic sgn, input logic [XLEN-1:0] x);
        mag = (sgn & x[XLEN-1]) ? -x : x;
    endfunction

    logic            idle, accept, req_div, req_sgn;
    logic [XLEN:0]   rem_sh;
    logic            rem_ge;
    logic [XLEN-1:0] rem_sub;
    logic [XLEN-1:0] div_lo, div_hi;

    assign idle    = (state_q == StIdle);
    assign bus.req_ready = resetn & idle & ~bus.flush & ~bus.mthi_we & ~bus.mtlo_we;
    assign accept  = bus.req_valid & bus.req_ready;
    assign req_div = (bus.req_op[2:1] == 2'b01);
    assign req_sgn = ~bus.req_op[0];

    // Remainder stays below the divisor, so only the low XLEN bits of the subtraction matter.
    assign rem_sh  = {r_q, a_q[XLEN-1]};
    assign rem_ge  = (rem_sh >= {1'b0, b_q});
    assign rem_sub = rem_sh[XLEN-1:0] - b_q;

    always_comb begin
        div_lo = qneg_q ? -a_q : a_q;
        div_hi = rneg_q ? -r_q : r_q;
        if (b_q == '0) begin
            div_lo = '1;
            div_hi = dvd_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        dvd_d   = dvd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!bus.flush) begin
                    if (bus.mthi_we) hi_d = bus.mt_wdata;
                    if (bus.mtlo_we) lo_d = bus.mt_wdata;
                end
                if (accept) begin
                    op_d = bus.req_op;
                    if (req_div) begin
                        state_d = StDiv;
                        cnt_d   = CntW'(XLEN - 1);
                        a_d     = mag(req_sgn, bus.req_src1);
                        b_d     = mag(req_sgn, bus.req_src2);
                        r_d     = '0;
                        dvd_d   = bus.req_src1;
                        qneg_d  = req_sgn & (bus.req_src1[XLEN-1] ^ bus.req_src2[XLEN-1]);
                        rneg_d  = req_sgn & bus.req_src1[XLEN-1];
                    end else if (MUL_LAT == 1) begin
                        {hi_d, lo_d} = mul_acc(bus.req_op, bus.req_src1, bus.req_src2,
                                               {hi_q, lo_q});
                        done_d       = 1'b1;
                    end else begin
                        state_d = StMul;
                        cnt_d   = CntW'(MUL_LAT - 2);
                        a_d     = bus.req_src1;
                        b_d     = bus.req_src2;
                    end
                end
            end
            StMul: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = mul_acc(op_q, a_q, b_q, {hi_q, lo_q});
                    done_d       = 1'b1;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDiv: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    r_d = rem_ge ? rem_sub : rem_sh[XLEN-1:0];
                    a_d = {a_q[XLEN-2:0], rem_ge};
                    if (cnt_q == '0) begin
                        state_d = StDfix;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StDfix: begin
                state_d = StIdle;
                if (!bus.flush) begin
                    hi_d   = div_hi;
                    lo_d   = div_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            dvd_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            dvd_q   <= dvd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = ~idle;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops against an
// arithmetic HI/LO model.
module tb_md_unit;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = XLEN + 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit_if #(.XLEN(XLEN)) bus ();

    md_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.mthi_we   = 1'b0;
        bus.mtlo_we   = 1'b0;
        bus.mt_wdata  = '0;
        bus.flush     = 1'b0;
    endtask

    // Architectural result of one operation on the model HI/LO.
    function automatic void model_op(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        longint          sp;
        longint unsigned up, p, acc;
        int              sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 3'd2 || op == 3'd3) begin
            if (b == 32'd0) begin
                m_lo = 32'hFFFF_FFFF;
                m_hi = a;
            end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                m_lo = 32'h8000_0000;
                m_hi = 32'd0;
            end else if (op == 3'd2) begin
                m_lo = sa / sb;
                m_hi = sa % sb;
            end else begin
                m_lo = a / b;
                m_hi = a % b;
            end
        end else begin
            sp  = longint'(sa) * longint'(sb);
            up  = longint'({32'd0, a}) * longint'({32'd0, b});
            p   = (op == 3'd1 || op == 3'd5 || op == 3'd7) ? up : sp;
            acc = {m_hi, m_lo};
            if (op == 3'd4 || op == 3'd5) acc = acc + p;
            else if (op == 3'd6 || op == 3'd7) acc = acc - p;
            else acc = p;
            {m_hi, m_lo} = acc;
        end
    endfunction

    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        bus.mthi_we  = h;
        bus.mtlo_we  = l;
        bus.mt_wdata = d;
        step();
        bus.mthi_we = 1'b0;
        bus.mtlo_we = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
        n_tests++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) begin
            n_fail++;
            $display("FAIL mt_write: hi=%h lo=%h required hi=%h lo=%h", bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    // Issues one op, waits for done, checks latency, busy/ready profile and HI/LO.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        int exp_lat, lat, nbusy, nlow;
        exp_lat = (op == 3'd2 || op == 3'd3) ? DIV_LAT : MUL_LAT;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        bus.req_valid = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: req_ready=%b required 1", tag, bus.req_ready);
        end
        step();
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_src1  = $urandom;
        bus.req_src2  = $urandom;
        model_op(op, a, b);
        lat   = 0;
        nbusy = 0;
        nlow  = 0;
        for (int c = 1; c <= int'(DIV_LAT) + 10; c++) begin
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            if (bus.busy === 1'b1) nbusy++;
            if (bus.req_ready !== 1'b1) nlow++;
            step();
        end
        n_tests++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: done in cycle %0d required %0d (0 = never)",
                     tag, lat, exp_lat);
        end
        n_tests++;
        if (nbusy != exp_lat - 1 || nlow != exp_lat - 1 || bus.busy !== 1'b0 ||
            bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s handshake: busy cycles=%0d ready-low cycles=%0d busy=%b ready=%b required %0d/%0d/0/1",
                     tag, nbusy, nlow, bus.busy, bus.req_ready, exp_lat - 1, exp_lat - 1);
        end
        n_tests++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) begin
            n_fail++;
            $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h",
                     tag, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        #3;
        n_tests++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b ready=%b required all zero",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.req_ready);
        end
        #9;
        resetn = 1'b1;
        step();
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: ready=%b busy=%b required 1/0", bus.req_ready, bus.busy);
        end
    endtask

    task automatic test_mult();
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, "mult");
        n_tests++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
            n_fail++;
            $display("FAIL mult_const: hi=%h lo=%h required ffffffff/fffffffa", bus.hi, bus.lo);
        end
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, "multu");
        n_tests++;
        if (bus.hi !== 32'h0000_0002 || bus.lo !== 32'hFFFF_FFFA) begin
            n_fail++;
            $display("FAIL multu_const: hi=%h lo=%h required 00000002/fffffffa", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div();
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, "div");
        n_tests++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_const: hi=%h lo=%h required ffffffff/fffffffd", bus.hi, bus.lo);
        end
        issue(3'd3, 32'd100, 32'd7, "divu");
        n_tests++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            n_fail++;
            $display("FAIL divu_const: hi=%h lo=%h required 2/14", bus.hi, bus.lo);
        end
        issue(3'd3, 32'h8000_0000, 32'd0, "divu_zero");
        n_tests++;
        if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL divu_zero_const: hi=%h lo=%h required 80000000/ffffffff",
                     bus.hi, bus.lo);
        end
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
        n_tests++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
            n_fail++;
            $display("FAIL div_min_const: hi=%h lo=%h required 0/80000000", bus.hi, bus.lo);
        end
        issue(3'd2, 32'hFFFF_FFF9, 32'd0, "div_zero");
    endtask

    task automatic test_accum();
        mt_write(1'b1, 1'b0, 32'd5);
        mt_write(1'b0, 1'b1, 32'd13);
        issue(3'd6, 32'd1, 32'd14, "msub");
        n_tests++;
        if (bus.hi !== 32'd4 || bus.lo !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL msub_const: hi=%h lo=%h required 4/ffffffff", bus.hi, bus.lo);
        end
        issue(3'd5, 32'd2, 32'd3, "maddu");
        n_tests++;
        if (bus.hi !== 32'd5 || bus.lo !== 32'd5) begin
            n_fail++;
            $display("FAIL maddu_const: hi=%h lo=%h required 5/5", bus.hi, bus.lo);
        end
        mt_write(1'b1, 1'b1, 32'h1234_5678);
        issue(3'd4, 32'hFFFF_FFFF, 32'h7FFF_FFFF, "madd");
        issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "msubu");
    endtask

    task automatic test_flush();
        int seen;
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
        bus.req_op = 3'd2; bus.req_src1 = 32'd1000; bus.req_src2 = 32'd3; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_div_ready: ready=%b busy=%b required 1/0",
                     bus.req_ready, bus.busy);
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) seen++;
            step();
        end
        n_tests++;
        if (seen != 0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            n_fail++;
            $display("FAIL flush_div_result: done pulses=%0d hi=%h lo=%h required 0 %h %h",
                     seen, bus.hi, bus.lo, m_hi, m_lo);
        end
        // Flush in the last multiply cycle must suppress the write.
        bus.req_op = 3'd0; bus.req_src1 = 32'd7; bus.req_src2 = 32'd9; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b1;
        step();
        bus.flush = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.done === 1'b1) seen++;
            step();
        end
        n_tests++;
        if (seen != 0 || bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_mul: done pulses=%0d hi=%h lo=%h busy=%b required 0 %h %h 0",
                     seen, bus.hi, bus.lo, bus.busy, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid();
        mt_write(1'b1, 1'b1, 32'hA5A5_5A5A);
        bus.req_op = 3'd2; bus.req_src1 = 32'd77; bus.req_src2 = 32'd5; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        repeat (4) step();
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b required all zero",
                     bus.hi, bus.lo, bus.busy, bus.done);
        end
        m_hi = '0;
        m_lo = '0;
        step();
        #3;
        resetn = 1'b1;
        step();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: busy=%b ready=%b done=%b required 0/1/0",
                     bus.busy, bus.req_ready, bus.done);
        end
    endtask

    task automatic test_collision();
        bus.mthi_we  = 1'b1;
        bus.mt_wdata = 32'h0BAD_BEEF;
        bus.req_op = 3'd1; bus.req_src1 = 32'd6; bus.req_src2 = 32'd7; bus.req_valid = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_ready: req_ready=%b required 0", bus.req_ready);
        end
        step();
        bus.mthi_we = 1'b0;
        m_hi = 32'h0BAD_BEEF;
        n_tests++;
        if (bus.hi !== m_hi || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_mthi: hi=%h busy=%b required %h/0", bus.hi, bus.busy, m_hi);
        end
        issue(3'd1, 32'd6, 32'd7, "collide_held");
        bus.flush = 1'b1;
        bus.req_op = 3'd0; bus.req_src1 = 32'd3; bus.req_src2 = 32'd3; bus.req_valid = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_block_ready: req_ready=%b required 0", bus.req_ready);
        end
        step();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_block_accept: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        issue(3'd0, 32'h8000_0000, 32'h8000_0000, "b2b_mult");
        issue(3'd3, 32'hFFFF_FFFF, 32'd16, "b2b_divu");
        issue(3'd4, 32'd123, 32'hFFFF_FF00, "b2b_madd");
        issue(3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFD, "b2b_div");
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0)
                mt_write(1'($urandom), 1'($urandom), $urandom);
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
            if ((op == 3'd2 || op == 3'd3) && $urandom_range(0, 7) == 0) b = '0;
            if (op == 3'd2 && $urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            issue(op, a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_accum();
        test_flush();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Parametrised multiply/divide unit with architectural HI/LO registers. It is the successor to the HI/LO, MULT/DIV and MTHI/MTLO logic currently embedded in the execute stage. It adds the following:
- a valid/ready request handshake
- configurable operand width and multiply latency
- an in-house iterative divider, replacing the vendor divider IP
- MADD/MADDU/MSUB/MSUBU accumulate operations
- a flush that cleanly aborts in-flight work on exceptions or ERET

It sits beside the ALU in the execute stage.

Parameters:
XLEN, 32, operand width. HI and LO are each XLEN bits wide.
MUL_LAT, 2, multiply pipeline latency in cycles, ≥1.

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  unit can accept a request this cycle
req_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
req_src1  in  XLEN  rs value (dividend or multiplicand)
req_src2  in  XLEN  rt value (divisor or multiplier)
mthi_we  in  1  write HI from mt_wdata
mtlo_we  in  1  write LO from mt_wdata
mt_wdata  in  XLEN  MTHI/MTLO data
flush  in  1  abort any in-flight operation
busy  out  1  operation in flight
done  out  1  one-cycle pulse; hi/lo already hold the new result
hi  out  XLEN  HI register
lo  out  XLEN  LO register

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (resetn); both the polarity and the synchronicity are fixed.
- While resetn=0:
  - hi=0, lo=0, busy=0, done=0, req_ready=0.
  - State is IDLE.
  - A reset asserted mid-operation discards the operation immediately.
- req_ready = IDLE & ~flush & ~mthi_we & ~mtlo_we. A request is accepted on a clock edge where req_valid & req_ready; operands are latched at that edge.
- MTHI/MTLO:
  - Honoured only in IDLE and only when flush=0.
  - Written at the clock edge.
  - If both mthi_we and mtlo_we are high, both HI and LO are written.
  - Ignored while busy; the issuing stage must not issue MTHI/MTLO while busy.
- FSM states: IDLE, MUL, DIV, DFIX.
  - IDLE→MUL on accepting op 0,1,4-7.
  - IDLE→DIV on accepting op 2,3.
  - MUL counts MUL_LAT-1 cycles, then writes HI/LO and returns to IDLE.
  - DIV runs XLEN restoring iterations, 1 quotient bit per cycle, then goes to DFIX.
  - DFIX applies the sign fixup, writes HI/LO and returns to IDLE.
- busy=1 in every state other than IDLE.
- Latency: the accept edge ends cycle 0.
  - Multiply ops: done=1 in cycle MUL_LAT.
  - Divide ops: done=1 in cycle XLEN+2.
  - req_ready may return high in the done cycle, so back-to-back issue is allowed.
- Multiply:
  - The 2·XLEN product is signed for ops 0,4,6 and unsigned for ops 1,5,7.
  - MULT/MULTU: {hi,lo} ← product.
  - MADD/MADDU: {hi,lo} ← {hi,lo} + product, mod 2^(2·XLEN).
  - MSUB/MSUBU: {hi,lo} ← {hi,lo} − product, mod 2^(2·XLEN).
  - Accumulation uses the HI/LO values present at the write edge.
- Divide:
  - Signed ops divide operand magnitudes.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - lo ← quotient, hi ← remainder.
- Divide by zero, signed or unsigned: lo = all-ones, hi = dividend.
- Signed MIN/−1: lo = MIN, hi = 0.
- flush:
  - Effective in any state: the next state is IDLE, HI/LO are not written, and no done pulse occurs.
  - flush=1 in the final MUL or DFIX cycle suppresses the write.
  - flush blocks acceptance of a request in the same cycle.
  - done is registered, so a flush in the done cycle has no effect on that result.
- req_op/req_src1/req_src2 are ignored when no request is accepted.

Test Plan:
- MULT 0xFFFFFFFE×3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA, done in cycle 2, busy cycles 1–1. MULTU on the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, done in cycle 34. DIVU 100/7 → lo=14, hi=2. req_ready low in cycles 1–33.
- DIVU 0x80000000/0 → lo=0xFFFFFFFF, hi=0x80000000. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 5, MTLO 13, then MSUB 1×14 → hi=4, lo=0xFFFFFFFF. Then MADDU 2×3 → hi=5, lo=0x00000005.
- Start DIV, flush in cycle 10 → no done, hi/lo unchanged, req_ready=1 in cycle 11. Start DIV, drop resetn at cycle 5 → hi=lo=0 and busy=0 without waiting for a clock edge.
- mthi_we=1 with req_valid=1 in the same IDLE cycle → req_ready=0 and HI written. The request is held and accepted in the next cycle; flush with req_valid → not accepted.
